router_port_rx: RTL and testbench
=================================

Name: router_port_rx

Overview:
- Receive side of one router input port.
- Deserializes the bit-serial din/frame_n/valid_n packet protocol (4-bit destination address, pad field, LSB-first payload bytes) into parallel bytes.
- Buffers the bytes in a FIFO and presents them on a valid/ready stream toward the switch core.
- Drives busy_n back to the sender for flow control.

Parameters:
- ADDR_BITS, 4, width of the destination address field (serial bits).
- PAD_CYCLES, 5, number of pad cycles between address and payload.
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥4).
- AFULL_LEVEL, 12, FIFO occupancy at or above which busy_n is driven low.

Ports:
- clk  input  1  port clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial address/payload bit.
- frame_n  input  1  active-low frame; low for the whole packet, high on the final payload bit.
- valid_n  input  1  active-low payload bit qualifier.
- busy_n  output  1  active-low busy to the sender.
- m_valid  output  1  FIFO head entry valid.
- m_ready  input  1  consumer accepts the head entry.
- m_data  output  8  payload byte.
- m_addr  output  ADDR_BITS  destination address of the packet.
- m_last  output  1  final entry of the packet.
- m_err  output  1  entry terminates a malformed packet.
- err_o  output  1  one-cycle pulse on any protocol error.
- ovf_o  output  1  sticky overflow flag.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - FIFO emptied; state IDLE; counters 0.
  - busy_n=1, m_valid=0, m_data=0, m_addr=0, m_last=0, m_err=0, err_o=0, ovf_o=0.
  - Reset mid-packet discards the partial packet; no terminator entry is pushed.
- All inputs are sampled at posedge clk.
- FSM states: IDLE, ADDR, PAD, DATA.
- IDLE:
  - frame_n=1: remain in IDLE.
  - frame_n=0: din is address bit 0; capture it, set addr_cnt=1, go to ADDR. If ADDR_BITS=1, go to PAD instead.
  - valid_n is ignored.
- ADDR:
  - Each cycle with frame_n=0: capture din into address bit addr_cnt (LSB first).
  - After bit ADDR_BITS-1, go to PAD with pad_cnt=0.
- PAD:
  - Count PAD_CYCLES cycles; din and valid_n are ignored.
  - Then go to DATA with bit_cnt=0.
- Abort in ADDR or PAD: frame_n=1 pulses err_o, returns to IDLE, pushes nothing.
- DATA, bit shifting:
  - valid_n=0: shift din into byte bit bit_cnt (LSB first), then bit_cnt++.
  - valid_n=1 with frame_n=0: stall; no shift.
- DATA, byte completion:
  - The 8th valid bit with frame_n=0 pushes {err=0, last=0, addr, byte}, bit_cnt=0, stay in DATA.
  - The 8th valid bit with frame_n=1 pushes {err=0, last=1, addr, byte} and goes to IDLE. This is normal end of packet.
- DATA, malformed end: frame_n=1 in any other case (partial byte, or valid_n=1):
  - Push terminator {err=1, last=1, addr, data = bits received so far, zero-filled}.
  - Pulse err_o; go to IDLE.
  - This applies even when no payload bit was received.
- Back-to-back packets: a new frame (frame_n=0) is accepted in the cycle immediately after returning to IDLE.
- FIFO:
  - Width 10+ADDR_BITS; show-ahead head entry on the m_* outputs.
  - Pop when m_valid & m_ready.
  - Push is allowed when not full, or when a pop occurs in the same cycle.
  - Push to a full FIFO with no pop: entry dropped, ovf_o set until reset.
  - Latency: byte completes at cycle T with FIFO empty → m_valid=1 at T+1.
- busy_n: registered; busy_n = 0 in the cycle after occupancy (post push/pop) ≥ AFULL_LEVEL, else 1.
- The sender honors busy_n only before starting a frame. An in-flight packet is never stalled by busy_n.

Test Plan:
- addr 4'h5, payload 0xA5, 0x3C, no stalls, m_ready=1 → entries {5,A5,last0,err0}, {5,3C,last1,err0}; first m_valid exactly 1 cycle after the 8th bit of 0xA5; err_o never pulses.
- Same packet with valid_n=1 for 3 cycles between bits 3 and 4 of each byte, then a second packet starting the cycle after frame_n rises → identical bytes; both packets captured, addresses correct.
- addr 4'h9, byte 0x11, then bits 1,0,1 with frame_n=1 on the third bit → entries {9,11,last0,err0}, {9,05,last1,err1}; err_o pulses once.
- frame_n rises during PAD cycle 2 → err_o pulses, FIFO stays empty, next packet is received correctly.
- m_ready=0, send 17 single-byte packets → busy_n=0 once 12 entries are held; 16 entries held; 17th dropped, ovf_o=1; draining restores busy_n=1 below 12.
- Assert reset for 1 cycle in the middle of a DATA byte with 2 entries queued → all outputs at reset values the next cycle, FIFO empty; a subsequent packet is received cleanly.

Source files
------------

// File: rtl/router_port_rx.sv
// Receive side of one router input port.
// Deserializes the din/frame_n/valid_n serial packet protocol (address,
// pad field, LSB-first payload bytes) into parallel bytes. The bytes are
// queued in a show-ahead FIFO and offered to the switch core on a
// valid/ready stream. busy_n gives the sender flow control.
module router_port_rx #(
    parameter int ADDR_BITS   = 4,
    parameter int PAD_CYCLES  = 5,
    parameter int FIFO_DEPTH  = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    input  logic                 frame_n,
    input  logic                 valid_n,
    output logic                 busy_n,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [7:0]           m_data,
    output logic [ADDR_BITS-1:0] m_addr,
    output logic                 m_last,
    output logic                 m_err,
    output logic                 err_o,
    output logic                 ovf_o
);

    localparam int ENTRY_W = 10 + ADDR_BITS;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ACNT_W  = $clog2(ADDR_BITS) + 1;
    localparam int PCNT_W  = $clog2(PAD_CYCLES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_PAD, S_DATA} state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [ACNT_W-1:0]    r_addr_cnt;
    logic [PCNT_W-1:0]    r_pad_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_byte;

    logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [ADDR_BITS-1:0] w_addr_shift;
    logic [7:0]           w_byte;
    logic                 w_push;
    logic [ENTRY_W-1:0]   w_entry;
    logic                 w_proto_err;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_fifo_wr;
    logic [CNT_W-1:0]     w_count_next;
    logic [ENTRY_W-1:0]   w_head;

    // Address arrives LSB first: shift each new bit in from the top, so after
    // ADDR_BITS shifts the first bit sits at the LSB.
    assign w_addr_shift = (r_addr >> 1) | (ADDR_BITS'(din) << (ADDR_BITS - 1));

    // Decode of the current serial cycle: merged byte, FIFO push and errors.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        w_byte      = r_byte;
        w_push      = 1'b0;
        w_entry     = '0;
        w_proto_err = 1'b0;
        if (!valid_n) begin
            w_byte[r_bit_cnt] = din;
        end
        unique case (r_state)
            S_ADDR, S_PAD: begin
                w_proto_err = frame_n;
            end
            S_DATA: begin
                if (!valid_n && r_bit_cnt == 3'd7) begin
                    w_push  = 1'b1;
                    w_entry = {1'b0, frame_n, r_addr, w_byte};
                end else if (frame_n) begin
                    // Frame ended on a partial byte or without a qualified bit.
                    w_push      = 1'b1;
                    w_entry     = {1'b1, 1'b1, r_addr, w_byte};
                    w_proto_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_pop        = m_valid & m_ready;
    assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_fifo_wr    = w_push & (~w_full | w_pop);
    assign w_count_next = r_count + CNT_W'(w_fifo_wr) - CNT_W'(w_pop);

    // Packet framing FSM with its address, pad and bit counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_addr_cnt <= '0;
            r_pad_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
            err_o      <= 1'b0;
        end else begin
            err_o <= w_proto_err;
            unique case (r_state)
                S_IDLE: begin
                    if (!frame_n) begin
                        r_addr     <= w_addr_shift;
                        r_addr_cnt <= ACNT_W'(1);
                        r_pad_cnt  <= '0;
                        r_state    <= (ADDR_BITS == 1) ? S_PAD : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (frame_n) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_addr <= w_addr_shift;
                        if (r_addr_cnt == ACNT_W'(ADDR_BITS - 1)) begin
                            r_pad_cnt <= '0;
                            r_state   <= S_PAD;
                        end else begin
                            r_addr_cnt <= r_addr_cnt + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (frame_n) begin
                        r_state <= S_IDLE;
                    end else if (r_pad_cnt == PCNT_W'(PAD_CYCLES - 1)) begin
                        r_bit_cnt <= '0;
                        r_byte    <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_pad_cnt <= r_pad_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_push) begin
                        r_bit_cnt <= '0;
                        r_byte    <= '0;
                        if (frame_n) begin
                            r_state <= S_IDLE;
                        end
                    end else if (!valid_n) begin
                        r_byte    <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; stale contents are harmless because only counted entries are shown.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; the pointers and count alone define validity.
        if (w_fifo_wr) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers, occupancy, overflow flag and registered busy_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            ovf_o    <= 1'b0;
            busy_n   <= 1'b1;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            if (w_push && !w_fifo_wr) begin
                ovf_o <= 1'b1;
            end
            busy_n <= ~(w_count_next >= CNT_W'(AFULL_LEVEL));
        end
    end

    // Show-ahead head entry, forced to zero while the FIFO is empty.
    assign m_valid = (r_count != '0);
    assign w_head  = m_valid ? r_mem[r_rd_ptr] : '0;
    assign m_err   = w_head[ENTRY_W-1];
    assign m_last  = w_head[ENTRY_W-2];
    assign m_addr  = w_head[8 +: ADDR_BITS];
    assign m_data  = w_head[7:0];

endmodule

// File: tb/tb_router_port_rx.sv
// Directed testbench for router_port_rx: serial packets in, FIFO entries out.
module tb_router_port_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic       busy_n;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [3:0] m_addr;
    logic       m_last;
    logic       m_err;
    logic       err_o;
    logic       ovf_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_cnt = 0;
    logic [13:0] got [$];

    router_port_rx #(
        .ADDR_BITS  (4),
        .PAD_CYCLES (5),
        .FIFO_DEPTH (16),
        .AFULL_LEVEL(12)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .frame_n(frame_n),
        .valid_n(valid_n),
        .busy_n (busy_n),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_addr (m_addr),
        .m_last (m_last),
        .m_err  (m_err),
        .err_o  (err_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk = ~clk;

    // Record accepted entries and error pulses away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) got.push_back({m_err, m_last, m_addr, m_data});
            if (err_o) err_cnt++;
        end
    end

    function automatic logic [13:0] ent(input logic e, input logic l,
                                        input logic [3:0] a, input logic [7:0] d);
        return {e, l, a, d};
    endfunction

    function automatic logic [13:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 14'h3fff;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_hdr(input logic [3:0] a);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, a[i]);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input int stall);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) repeat (stall) drive(1'b0, 1'b1, 1'b1);
            drive(last && (i == 7), 1'b0, d[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy_n"},  busy_n,  1);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"},  m_data,  0);
        check({tag, "_m_addr"},  m_addr,  0);
        check({tag, "_m_last"},  m_last,  0);
        check({tag, "_m_err"},   m_err,   0);
        check({tag, "_err_o"},   err_o,   0);
        check({tag, "_ovf_o"},   ovf_o,   0);
    endtask

    initial begin
        logic [7:0] b;
        int e0;

        reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        idle(2);

        // 1: addr 5, A5 then 3C, no stalls; first m_valid one cycle after bit 8.
        got.delete(); e0 = err_cnt;
        send_hdr(4'h5);
        b = 8'hA5;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, b[i]);
        check("t1_no_valid_before_bit8", m_valid, 0);
        drive(1'b0, 1'b0, b[7]);
        check("t1_valid_after_bit8", m_valid, 1);
        check("t1_head_data", m_data, 8'hA5);
        check("t1_head_addr", m_addr, 4'h5);
        send_byte(8'h3C, 1'b1, 0);
        idle(3);
        check("t1_count", got.size(), 2);
        check("t1_e0", got_at(0), ent(0, 0, 4'h5, 8'hA5));
        check("t1_e1", got_at(1), ent(0, 1, 4'h5, 8'h3C));
        check("t1_no_err", err_cnt - e0, 0);

        // 2: stalls between bits 3 and 4, back-to-back second packet.
        got.delete(); e0 = err_cnt;
        send_hdr(4'h5);
        send_byte(8'hA5, 1'b0, 3);
        send_byte(8'h3C, 1'b1, 3);
        send_hdr(4'h6);
        send_byte(8'hA5, 1'b0, 3);
        send_byte(8'h3C, 1'b1, 3);
        idle(3);
        check("t2_count", got.size(), 4);
        check("t2_e0", got_at(0), ent(0, 0, 4'h5, 8'hA5));
        check("t2_e1", got_at(1), ent(0, 1, 4'h5, 8'h3C));
        check("t2_e2", got_at(2), ent(0, 0, 4'h6, 8'hA5));
        check("t2_e3", got_at(3), ent(0, 1, 4'h6, 8'h3C));
        check("t2_no_err", err_cnt - e0, 0);

        // 3: malformed end after three bits 1,0,1.
        got.delete(); e0 = err_cnt;
        send_hdr(4'h9);
        send_byte(8'h11, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        idle(3);
        check("t3_count", got.size(), 2);
        check("t3_e0", got_at(0), ent(0, 0, 4'h9, 8'h11));
        check("t3_e1", got_at(1), ent(1, 1, 4'h9, 8'h05));
        check("t3_err_once", err_cnt - e0, 1);

        // 4: abort during PAD cycle 2, then a clean packet.
        got.delete(); e0 = err_cnt;
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        idle(2);
        check("t4_err_once", err_cnt - e0, 1);
        check("t4_fifo_empty", m_valid, 0);
        check("t4_nothing_pushed", got.size(), 0);
        send_hdr(4'h3);
        send_byte(8'h7E, 1'b1, 0);
        idle(3);
        check("t4_count", got.size(), 1);
        check("t4_e0", got_at(0), ent(0, 1, 4'h3, 8'h7E));

        // 5: fill with m_ready=0, busy_n at 12, overflow on the 17th.
        got.delete();
        m_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            send_hdr(4'hA);
            send_byte(8'(k), 1'b1, 0);
            check($sformatf("t5_busy_after_%0d", k), busy_n, (k >= 12) ? 0 : 1);
            check($sformatf("t5_ovf_after_%0d", k), ovf_o, (k >= 17) ? 1 : 0);
        end
        idle(1);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_busy_at_12", busy_n, 0);
        @(posedge clk);
        #1;
        check("t5_busy_at_11", busy_n, 1);
        repeat (12) @(posedge clk);
        #1;
        check("t5_drain_count", got.size(), 16);
        check("t5_drained", m_valid, 0);
        check("t5_first", got_at(0), ent(0, 1, 4'hA, 8'd1));
        check("t5_sixteenth", got_at(15), ent(0, 1, 4'hA, 8'd16));
        check("t5_ovf_sticky", ovf_o, 1);

        // 6: reset mid-byte with two entries queued.
        got.delete(); e0 = err_cnt;
        m_ready = 1'b0;
        send_hdr(4'h2);
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("t6_queued", m_valid, 1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        check_reset_outputs("t6_rst");
        m_ready = 1'b1;
        idle(1);
        send_hdr(4'hC);
        send_byte(8'h5A, 1'b1, 0);
        idle(3);
        check("t6_count", got.size(), 1);
        check("t6_e0", got_at(0), ent(0, 1, 4'hC, 8'h5A));
        check("t6_no_err", err_cnt - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
